// File: rtl/regfile_responder.sv
// ---------------------------------------------------------------------------
// regfile_responder
//
// Responder end of the processor-to-register-file op handshake. Holds a
// 32 x 16-bit register file with two read ports and one write port. A
// non-zero 3-bit request word is captured in IDLE together with all
// addresses and write data. The block then spends ACCESS_CYCLES edges in
// ACCESS, performs the optional write in WRITE, and signals completion with
// a single-cycle registered dne pulse in RESP. It then waits in HOLD until
// the initiator returns the request word to 3'b000.
//
// Parameters
//   ACCESS_CYCLES  clock edges spent in ACCESS before read data updates (1-15)
//
// Ports
//   clk         in   1   single clock, all state on posedge
//   rst_n       in   1   asynchronous active-low reset
//   ops         in   3   request: bit2 read port 1, bit1 read port 2, bit0 write
//   read1       in   5   read address, port 1
//   read2       in   5   read address, port 2
//   write       in   5   write address
//   local_data  in  16   write data (the name "local" is a reserved word)
//   readt1      out 16   port-1 read data, holds until the port is read again
//   readt2      out 16   port-2 read data, holds until the port is read again
//   dne         out  1   completion pulse, registered, one cycle wide
// ---------------------------------------------------------------------------
module regfile_responder #(
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  ops,
    input  logic [4:0]  read1,
    input  logic [4:0]  read2,
    input  logic [4:0]  write,
    input  logic [15:0] local_data,
    output logic [15:0] readt1,
    output logic [15:0] readt2,
    output logic        dne
);

    // State encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCESS = 3'd1;
    localparam logic [2:0] ST_WRITE  = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    // Count value on which ACCESS finishes; cnt starts at 0 after accept.
    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    localparam int unsigned NUM_REGS = 32;

    logic [2:0]  state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [2:0]  ops_q,     ops_d;
    logic [4:0]  read1_q,   read1_d;
    logic [4:0]  read2_q,   read2_d;
    logic [4:0]  write_q,   write_d;
    logic [15:0] local_q,   local_d;
    logic [15:0] readt1_q,  readt1_d;
    logic [15:0] readt2_q,  readt2_d;
    logic        dne_q,     dne_d;
    logic [15:0] rf_q [NUM_REGS];
    logic [15:0] rf_d [NUM_REGS];

    // Next-state, capture, read-out and write-back logic for the op sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ops_d    = ops_q;
        read1_d  = read1_q;
        read2_d  = read2_q;
        write_d  = write_q;
        local_d  = local_q;
        readt1_d = readt1_q;
        readt2_d = readt2_q;
        dne_d    = 1'b0;
        rf_d     = rf_q;

        case (state_q)
            ST_IDLE: begin
                if (ops != 3'b000) begin
                    // Everything the op needs is frozen here; later input
                    // changes cannot disturb an operation in flight.
                    ops_d   = ops;
                    read1_d = read1;
                    read2_d = read2;
                    write_d = write;
                    local_d = local_data;
                    cnt_d   = 4'd0;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    // Reads sample the array before any write of this op,
                    // so a same-address read+write returns the old value.
                    if (ops_q[2]) begin
                        readt1_d = rf_q[read1_q];
                    end else begin
                        readt1_d = readt1_q;
                    end
                    if (ops_q[1]) begin
                        readt2_d = rf_q[read2_q];
                    end else begin
                        readt2_d = readt2_q;
                    end
                    if (ops_q[0]) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RESP;
                        dne_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end

            ST_WRITE: begin
                rf_d[write_q] = local_q;
                state_d       = ST_RESP;
                dne_d         = 1'b1;
            end

            ST_RESP: begin
                // dne was raised on entry; leaving RESP drops it.
                state_d = ST_HOLD;
                dne_d   = 1'b0;
            end

            ST_HOLD: begin
                // A held request is never re-executed; a 000 gap is needed.
                if (ops == 3'b000) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dne_d   = 1'b0;
            end
        endcase
    end

    // Control, capture and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ops_q    <= 3'b000;
            read1_q  <= 5'd0;
            read2_q  <= 5'd0;
            write_q  <= 5'd0;
            local_q  <= 16'h0000;
            readt1_q <= 16'h0000;
            readt2_q <= 16'h0000;
            dne_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ops_q    <= ops_d;
            read1_q  <= read1_d;
            read2_q  <= read2_d;
            write_q  <= write_d;
            local_q  <= local_d;
            readt1_q <= readt1_d;
            readt2_q <= readt2_d;
            dne_q    <= dne_d;
        end
    end

    // Register file storage; reset clears every entry to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign readt1 = readt1_q;
    assign readt2 = readt2_q;
    assign dne    = dne_q;

endmodule

// File: tb/tb_regfile_responder.sv
// ---------------------------------------------------------------------------
// tb_regfile_responder
//
// Three responders with ACCESS_CYCLES = 1, 3 and 4, each with its own
// request and reset signals. A behavioural model (an array per instance plus
// the last value seen on each read port) predicts read data, and the dne
// latency is predicted from the op type and the instance's access cycles.
// ---------------------------------------------------------------------------
module tb_regfile_responder;

    logic        clk;
    logic        rst_n_a  [3];
    logic [2:0]  ops_a    [3];
    logic [4:0]  rd1_a    [3];
    logic [4:0]  rd2_a    [3];
    logic [4:0]  wr_a     [3];
    logic [15:0] loc_a    [3];
    logic [15:0] rt1_a    [3];
    logic [15:0] rt2_a    [3];
    logic        dne_a    [3];

    // Behavioural model state
    logic [15:0] m_rf [3][32];
    logic [15:0] m_r1 [3];
    logic [15:0] m_r2 [3];

    int vectors;
    int miscompares;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        regfile_responder #(
            .ACCESS_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n_a[g]),
            .ops        (ops_a[g]),
            .read1      (rd1_a[g]),
            .read2      (rd2_a[g]),
            .write      (wr_a[g]),
            .local_data (loc_a[g]),
            .readt1     (rt1_a[g]),
            .readt2     (rt2_a[g]),
            .dne        (dne_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int a_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset(input int d);
        for (int i = 0; i < 32; i++) m_rf[d][i] = 16'h0000;
        m_r1[d] = 16'h0000;
        m_r2[d] = 16'h0000;
    endtask

    // One complete handshake on instance d, checking latency, data and the
    // single-cycle dne pulse. After accept, read1 is switched to late_r1 and
    // the other inputs are scrambled; none of this may affect the result.
    task automatic run_op(input int d, input logic [2:0] op,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] w, input logic [15:0] data,
                          input logic [4:0] late_r1);
        int          lat;
        int          exp_lat;
        logic [15:0] e1;
        logic [15:0] e2;
        if (op[2]) m_r1[d] = m_rf[d][r1];
        if (op[1]) m_r2[d] = m_rf[d][r2];
        e1 = m_r1[d];
        e2 = m_r2[d];
        if (op[0]) m_rf[d][w] = data;
        exp_lat = a_of(d) + (op[0] ? 1 : 0);

        @(negedge clk);
        ops_a[d] = op; rd1_a[d] = r1; rd2_a[d] = r2; wr_a[d] = w; loc_a[d] = data;
        @(posedge clk);
        #1;
        rd1_a[d] = late_r1;
        rd2_a[d] = 5'($urandom_range(31, 0));
        wr_a[d]  = 5'($urandom_range(31, 0));
        loc_a[d] = 16'($urandom_range(65535, 0));
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (dne_a[d] === 1'b1) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL dne_latency d=%0d op=%b got=%0d exp=%0d", d, op, lat, exp_lat);
        end
        vectors++;
        if (rt1_a[d] !== e1) begin
            miscompares++;
            $display("FAIL readt1 d=%0d op=%b got=%h exp=%h", d, op, rt1_a[d], e1);
        end
        vectors++;
        if (rt2_a[d] !== e2) begin
            miscompares++;
            $display("FAIL readt2 d=%0d op=%b got=%h exp=%h", d, op, rt2_a[d], e2);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (dne_a[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL dne_width d=%0d op=%b got=%b exp=0", d, op, dne_a[d]);
        end
        @(negedge clk);
        ops_a[d] = 3'b000;
        @(posedge clk);
    endtask

    task automatic test_reset;
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (rt1_a[d] !== 16'h0000 || rt2_a[d] !== 16'h0000 || dne_a[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs d=%0d got=%h/%h/%b exp=0000/0000/0",
                         d, rt1_a[d], rt2_a[d], dne_a[d]);
            end
            // Every entry starts at zero: read a couple of arbitrary ones.
            run_op(d, 3'b110, 5'd31, 5'd17, 5'd0, 16'h0000, 5'd3);
        end
    endtask

    task automatic test_write_read;
        run_op(0, 3'b001, 5'd0, 5'd0, 5'd5, 16'hBEEF, 5'd0);
        run_op(0, 3'b100, 5'd5, 5'd0, 5'd0, 16'h0000, 5'd9);
    endtask

    task automatic test_dual_read;
        run_op(0, 3'b001, 5'd0, 5'd0, 5'd3, 16'h0011, 5'd0);
        run_op(0, 3'b001, 5'd0, 5'd0, 5'd7, 16'h2200, 5'd0);
        run_op(0, 3'b110, 5'd3, 5'd7, 5'd0, 16'h0000, 5'd1);
        run_op(0, 3'b100, 5'd7, 5'd0, 5'd0, 16'h0000, 5'd3);
    endtask

    task automatic test_read_before_write;
        run_op(0, 3'b001, 5'd0, 5'd0, 5'd9, 16'h1234, 5'd0);
        run_op(0, 3'b111, 5'd9, 5'd9, 5'd9, 16'h5678, 5'd9);
        run_op(0, 3'b110, 5'd9, 5'd9, 5'd0, 16'h0000, 5'd9);
    endtask

    task automatic test_hold;
        int highs;
        m_r1[0] = m_rf[0][5'd3];
        @(negedge clk);
        ops_a[0] = 3'b100; rd1_a[0] = 5'd3;
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (dne_a[0] === 1'b1) highs++;
        end
        vectors++;
        if (highs !== 1) begin
            miscompares++;
            $display("FAIL hold_single_pulse got=%0d exp=1", highs);
        end
        vectors++;
        if (rt1_a[0] !== m_r1[0]) begin
            miscompares++;
            $display("FAIL hold_readt1 got=%h exp=%h", rt1_a[0], m_r1[0]);
        end
        @(negedge clk);
        ops_a[0] = 3'b000;
        @(negedge clk);
        ops_a[0] = 3'b100; rd1_a[0] = 5'd5;
        m_r1[0] = m_rf[0][5'd5];
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (dne_a[0] === 1'b1) highs++;
        end
        vectors++;
        if (highs !== 1) begin
            miscompares++;
            $display("FAIL hold_second_pulse got=%0d exp=1", highs);
        end
        vectors++;
        if (rt1_a[0] !== m_r1[0]) begin
            miscompares++;
            $display("FAIL hold_second_readt1 got=%h exp=%h", rt1_a[0], m_r1[0]);
        end
        @(negedge clk);
        ops_a[0] = 3'b000;
        @(posedge clk);
    endtask

    task automatic test_latency;
        run_op(2, 3'b001, 5'd0, 5'd0, 5'd12, 16'hC0DE, 5'd0);
        run_op(2, 3'b100, 5'd12, 5'd0, 5'd0, 16'h0000, 5'd1);
        run_op(2, 3'b011, 5'd0, 5'd12, 5'd12, 16'h4321, 5'd0);
        run_op(2, 3'b110, 5'd12, 5'd12, 5'd0, 16'h0000, 5'd2);
    endtask

    task automatic test_reset_mid_op;
        run_op(1, 3'b001, 5'd0, 5'd0, 5'd10, 16'h5A5A, 5'd0);
        run_op(1, 3'b110, 5'd10, 5'd10, 5'd0, 16'h0000, 5'd0);
        @(negedge clk);
        ops_a[1] = 3'b001; wr_a[1] = 5'd2; loc_a[1] = 16'hAAAA;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n_a[1] = 1'b0;
        #1;
        model_reset(1);
        vectors++;
        if (dne_a[1] !== 1'b0 || rt1_a[1] !== 16'h0000 || rt2_a[1] !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_op got=%h/%h/%b exp=0000/0000/0",
                     rt1_a[1], rt2_a[1], dne_a[1]);
        end
        ops_a[1] = 3'b000;
        @(negedge clk);
        rst_n_a[1] = 1'b1;
        run_op(1, 3'b110, 5'd2, 5'd10, 5'd0, 16'h0000, 5'd0);
    endtask

    task automatic test_input_change;
        run_op(0, 3'b001, 5'd0, 5'd0, 5'd4, 16'h0F0F, 5'd0);
        run_op(0, 3'b001, 5'd0, 5'd0, 5'd6, 16'h7777, 5'd0);
        run_op(0, 3'b100, 5'd4, 5'd0, 5'd0, 16'h0000, 5'd6);
    endtask

    task automatic test_random;
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 30; n++) begin
                // Narrow address range so reads often hit recent writes.
                run_op(d, 3'($urandom_range(7, 1)),
                       5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                       5'($urandom_range(7, 0)), 16'($urandom_range(65535, 0)),
                       5'($urandom_range(31, 0)));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int d = 0; d < 3; d++) begin
            rst_n_a[d] = 1'b0;
            ops_a[d]   = 3'b000;
            rd1_a[d]   = 5'd0;
            rd2_a[d]   = 5'd0;
            wr_a[d]    = 5'd0;
            loc_a[d]   = 16'h0000;
            model_reset(d);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n_a[d] = 1'b1;

        test_reset();
        test_write_read();
        test_dual_read();
        test_read_before_write();
        test_hold();
        test_latency();
        test_reset_mid_op();
        test_input_change();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
